ads5404_init_ctrl: RTL

Bring-up and supervision sequencer for the ADS5404 dual-ADC capture interface. It drives the capture block's control inputs (user_rst, user_enable, user_sync) through a fixed power-up, reset, PLL-lock and SYNC sequence, then watches the capture PLL lock. On loss of lock it re-runs the sequence, up to a retry limit. It runs on a free-running fabric clock, not on the ADC-derived clkout, which is absent until the PLL locks.

---
 rtl/ads5404_init_ctrl_if.sv | 26 ++
 rtl/ads5404_init_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ads5404_init_ctrl_if.sv
// Control and status bundle between the ADS5404 bring-up sequencer and its surroundings.
// The master side is the sequencer: it consumes start/pll_locked and drives everything else.
interface ads5404_init_ctrl_if;
   logic        start;
   logic        pll_locked;
   logic        user_rst;
   logic        user_enable;
   logic        user_sync;
   logic        ready;
   logic        error;
   logic [2:0]  state;
   logic [3:0]  retry_count;
   logic [15:0] lock_loss_count;

   modport master (
      input  start, pll_locked,
      output user_rst, user_enable, user_sync, ready, error,
             state, retry_count, lock_loss_count
   );

   modport slave (
      output start, pll_locked,
      input  user_rst, user_enable, user_sync, ready, error,
             state, retry_count, lock_loss_count
   );
endinterface

// File: rtl/ads5404_init_ctrl.sv
// ADS5404 capture bring-up sequencer: power-up, reset, PLL lock, SYNC, settle,
// then supervision of the capture PLL lock with a bounded number of re-sequences.
// Runs on the free-running fabric clock; pll_locked is resynchronized locally.
module ads5404_init_ctrl #(
   parameter int PWRUP_CYCLES  = 256,
   parameter int RST_CYCLES    = 64,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int SYNC_CYCLES   = 16,
   parameter int SETTLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3
) (
   input logic                 clk,
   input logic                 rst,
   ads5404_init_ctrl_if.master ctl
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PWRUP     = 3'd1,
      ST_RESET     = 3'd2,
      ST_WAIT_LOCK = 3'd3,
      ST_SYNC      = 3'd4,
      ST_SETTLE    = 3'd5,
      ST_RUN       = 3'd6,
      ST_FAIL      = 3'd7
   } state_t;

   // One shared down-counter times every state; size it for the longest one.
   localparam int MAX_A   = (PWRUP_CYCLES > RST_CYCLES) ? PWRUP_CYCLES : RST_CYCLES;
   localparam int MAX_B   = (LOCK_TIMEOUT > SYNC_CYCLES) ? LOCK_TIMEOUT : SYNC_CYCLES;
   localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_ALL = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_ALL) + 1;

   // retry_count is 4 bits wide, so a larger limit behaves as 15.
   localparam logic [3:0] RETRY_LIMIT = (MAX_RETRIES > 15) ? 4'd15 : 4'(MAX_RETRIES);

   logic             lock_meta_reg;
   logic             lock_s_reg;
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [3:0]       retry_reg, retry_next;
   logic [15:0]      loss_reg, loss_next;
   logic             retry_evt;
   logic             user_rst_reg, user_rst_next;
   logic             user_enable_reg, user_enable_next;
   logic             user_sync_reg, user_sync_next;
   logic             ready_reg, ready_next;
   logic             error_reg, error_next;

   // Counter preload on state entry: the state then lasts exactly N cycles.
   function automatic logic [CNT_W-1:0] entry_count(input state_t s);
      case (s)
         ST_PWRUP:     entry_count = CNT_W'(PWRUP_CYCLES - 1);
         ST_RESET:     entry_count = CNT_W'(RST_CYCLES - 1);
         ST_WAIT_LOCK: entry_count = CNT_W'(LOCK_TIMEOUT - 1);
         ST_SYNC:      entry_count = CNT_W'(SYNC_CYCLES - 1);
         ST_SETTLE:    entry_count = CNT_W'(SETTLE_CYCLES - 1);
         default:      entry_count = '0;
      endcase
   endfunction

   // Two-flop synchronizer for the asynchronous PLL lock.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_meta_reg <= 1'b0;
         lock_s_reg    <= 1'b0;
      end else begin
         lock_meta_reg <= ctl.pll_locked;
         lock_s_reg    <= lock_meta_reg;
      end
   end

   // Next-state logic, including the shared retry-event resolution.
   always_comb begin
      state_next = state_reg;
      retry_next = retry_reg;
      loss_next  = loss_reg;
      retry_evt  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (ctl.start) begin
               state_next = ST_PWRUP;
               retry_next = '0;
            end
         end
         ST_PWRUP:  if (cnt_reg == '0) state_next = ST_RESET;
         ST_RESET:  if (cnt_reg == '0) state_next = ST_WAIT_LOCK;
         ST_WAIT_LOCK: begin
            if (lock_s_reg)          state_next = ST_SYNC;
            else if (cnt_reg == '0)  retry_evt  = 1'b1;
         end
         // Lock loss during SYNC is deliberately ignored; SETTLE checks the level,
         // so a loss that began in SYNC is still caught on SETTLE entry.
         ST_SYNC:   if (cnt_reg == '0) state_next = ST_SETTLE;
         ST_SETTLE: begin
            if (!lock_s_reg)         retry_evt  = 1'b1;
            else if (cnt_reg == '0)  state_next = ST_RUN;
         end
         // RUN is only entered with lock_s high, so the first low cycle is the falling edge.
         ST_RUN: begin
            if (!lock_s_reg) begin
               retry_evt = 1'b1;
               if (loss_reg != 16'hFFFF) loss_next = loss_reg + 16'd1;
            end
         end
         ST_FAIL: begin
            if (ctl.start) begin
               state_next = ST_PWRUP;
               retry_next = '0;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      // Enable stays high on a retry, so power-up is skipped and we go straight to RESET.
      if (retry_evt) begin
         if (retry_reg < RETRY_LIMIT) begin
            retry_next = retry_reg + 4'd1;
            state_next = ST_RESET;
         end else begin
            state_next = ST_FAIL;
         end
      end
   end

   // Counter: preload when the state changes, otherwise count down and hold at zero.
   always_comb begin
      cnt_next = cnt_reg;
      if (state_next != state_reg)
         cnt_next = entry_count(state_next);
      else if (cnt_reg != '0)
         cnt_next = cnt_reg - 1'b1;
   end

   // Output decode from the next state so the outputs are registered with the state.
   always_comb begin
      user_rst_next    = 1'b0;
      user_enable_next = 1'b0;
      user_sync_next   = 1'b0;
      ready_next       = 1'b0;
      error_next       = 1'b0;
      case (state_next)
         ST_IDLE:                 user_rst_next = 1'b1;
         ST_PWRUP, ST_RESET: begin
            user_rst_next    = 1'b1;
            user_enable_next = 1'b1;
         end
         ST_WAIT_LOCK, ST_SETTLE: user_enable_next = 1'b1;
         ST_SYNC: begin
            user_enable_next = 1'b1;
            user_sync_next   = 1'b1;
         end
         ST_RUN: begin
            user_enable_next = 1'b1;
            ready_next       = 1'b1;
         end
         ST_FAIL: begin
            user_rst_next = 1'b1;
            error_next    = 1'b1;
         end
         default:                 user_rst_next = 1'b1;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         retry_reg       <= '0;
         loss_reg        <= '0;
         user_rst_reg    <= 1'b1;
         user_enable_reg <= 1'b0;
         user_sync_reg   <= 1'b0;
         ready_reg       <= 1'b0;
         error_reg       <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         retry_reg       <= retry_next;
         loss_reg        <= loss_next;
         user_rst_reg    <= user_rst_next;
         user_enable_reg <= user_enable_next;
         user_sync_reg   <= user_sync_next;
         ready_reg       <= ready_next;
         error_reg       <= error_next;
      end
   end

   assign ctl.user_rst        = user_rst_reg;
   assign ctl.user_enable     = user_enable_reg;
   assign ctl.user_sync       = user_sync_reg;
   assign ctl.ready           = ready_reg;
   assign ctl.error           = error_reg;
   assign ctl.state           = state_reg;
   assign ctl.retry_count     = retry_reg;
   assign ctl.lock_loss_count = loss_reg;

endmodule
